gemm_tile_sequencer: RTL and testbench
======================================

GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 Parameters SHALL be: BLK_M 16 (rows per tile); BLK_K 16 (tile depth); BLK_N 16 (tile width); DIM_W 16 (matrix-dimension width); BASE_ADDR 32'h9000_0000 (gemm register base); all BLK_* values SHALL be 1..31.
REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the job.
- dim_m, dim_k, dim_n  in  DIM_W each  matrix dimensions M, K, N.
- a_base, b_base, c_base  in  32 each  matrix base addresses.
- bus_en  out  1  system bus enable.
- bus_rdwr  out  1  1 = write, 0 = read.
- bus_addr  out  32  system bus address.
- bus_wr_data  out  32  system bus write data.
- bus_rd_data  in  32  read data, valid one cycle after a read request.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared by the next accepted start.
- tile_cnt  out  16  number of tiles issued in the current job.
- perf_cycles  out  32  busy-cycle count.
- perf_stall  out  32  full-poll stall count.

Function
REQ-003 Start SHALL be accepted only in IDLE; dims and bases SHALL be latched at that edge; start SHALL be ignored while busy=1.
REQ-004 If any dim is zero at start, the block SHALL issue no bus traffic, set err=1, and pulse done=1 on the next cycle.
REQ-005 Loop order SHALL be n outer (step BLK_N), m middle (step BLK_M), k inner (step BLK_K).
REQ-006 Tile sizes SHALL be nsize=min(BLK_N,N-n), msize=min(BLK_M,M-m), ksize=min(BLK_K,K-k); a zero remainder SHALL never be produced.
REQ-007 Tile flags SHALL be first=(k==0) and last=(k+BLK_K>=K).
REQ-008 Tile addresses SHALL be:
- A = a_base+m*K+k.
- B = b_base+n+(k+ksize-1)*N.
- C = c_base+m*N+n.
- All arithmetic SHALL be 32-bit unsigned with wrap.
REQ-009 For each tile, the FSM SHALL write one register per cycle, with bus_en=1 and bus_rdwr=1, in this order:
- WR_ASTR: BASE+12 <= K.
- WR_BSTR: BASE+16 <= N.
- WR_AADDR: BASE+0 <= A.
- WR_BADDR: BASE+4 <= B.
- WR_CADDR: BASE+8 <= C.
- WR_CTRL: BASE+20 <= {first,last}.
- WR_DIM: BASE+24 <= msize | ksize<<5 | nsize<<10.
REQ-010 POLL_FULL SHALL drive bus_en=1, bus_rdwr=0, bus_addr=BASE; from the second POLL_FULL cycle onward, bus_rd_data[0]==0 SHALL advance to NEXT, else the FSM SHALL stay.
REQ-011 NEXT SHALL increment tile_cnt, advance k/m/n, and go to WR_ASTR, or to POLL_DONE after the final tile.
REQ-012 POLL_DONE SHALL read BASE+24 using the same one-cycle-latency rule; bus_rd_data[0]==1 SHALL go to IDLE with done=1 for one cycle and busy=0.
REQ-013 In IDLE, bus_en SHALL be 0; bus_addr and bus_wr_data SHALL hold their last values.
REQ-014 The minimum tile period SHALL be 9 cycles (7 writes, 2 poll cycles), plus 1 NEXT cycle.
REQ-015 A start pulse coincident with done SHALL be ignored.

Reset
REQ-016 rst=0 SHALL asynchronously force IDLE and clear bus_en, bus_rdwr, bus_addr, bus_wr_data, busy, done, err, tile_cnt, perf_cycles and perf_stall to 0.
REQ-017 Reset mid-job SHALL abandon the job with no further bus traffic after rst rises; the gemm register state is not restored.

Configuration
REQ-018 With GEMM_SEQ_PERF_CNT_EN defined:
- perf_cycles SHALL count cycles with busy=1.
- perf_stall SHALL count POLL_FULL cycles where bus_rd_data[0]==1.
- Both SHALL clear on an accepted start and saturate at all-ones.
REQ-019 Without GEMM_SEQ_PERF_CNT_EN, perf_cycles and perf_stall SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-020 Single tile: M=K=N=16, bases 0/256/512, gemm never full.
- 7 writes with A=0, B=256+15*16=496, C=512, CTRL=3, DIM=16|16<<5|16<<10.
- done pulses after the done read; tile_cnt=1.
REQ-021 Ragged tiling: M=K=N=20, B base 400, C base 800.
- 8 tiles; tile_cnt=8.
- Final tile (n=16, m=16, k=16): A=336, B=400+16+19*20=796, C=800+336=1136, CTRL=1, DIM=4|4<<5|4<<10.
REQ-022 Backpressure: bus_rd_data[0] held at 1 for 5 POLL_FULL cycles -> no write is issued during that time; perf_stall=5 when the macro is defined.
REQ-023 Zero dimension: start with dim_k=0 -> bus_en stays 0, err=1, done pulses one cycle later; a later valid start clears err.
REQ-024 Reset mid-job: rst=0 during WR_BADDR of tile 3 -> all outputs 0 immediately; no bus_en after release; a new start runs from tile 0.
REQ-025 Start while busy: a second start pulse mid-job is ignored, and a start coincident with done is ignored -> the latched dims are unchanged and the tile sequence is identical to the single-start run.

Source files
------------

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer
//   Walks an M x K x N matrix multiply in BLK_M x BLK_K x BLK_N tiles
//   (n outer, m middle, k inner). For each tile it programs the gemm
//   register block over a single-beat system bus and waits until the engine
//   has room for the next tile. After the last tile it polls for completion.
//   Bus read data arrives one cycle after the read request, so each poll
//   ignores the data returned in its first cycle.
//
//   Optional feature: define GEMM_SEQ_PERF_CNT_EN to build the busy-cycle
//   and full-stall counters. Without it both counters read as constant 0.
//
//   BLK_M, BLK_K and BLK_N must be 1..31 so each tile size fits the 5-bit
//   fields of the DIM register. DIM_W must be at least 5.
module gemm_tile_sequencer #(
    parameter int          BLK_M     = 16,
    parameter int          BLK_K     = 16,
    parameter int          BLK_N     = 16,
    parameter int          DIM_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_k,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [31:0]      a_base,
    input  logic [31:0]      b_base,
    input  logic [31:0]      c_base,
    output logic             bus_en,
    output logic             bus_rdwr,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wr_data,
    input  logic [31:0]      bus_rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      tile_cnt,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall
);

    // Register offsets inside the gemm block.
    localparam logic [31:0] OFS_AADDR = 32'd0;
    localparam logic [31:0] OFS_BADDR = 32'd4;
    localparam logic [31:0] OFS_CADDR = 32'd8;
    localparam logic [31:0] OFS_ASTR  = 32'd12;
    localparam logic [31:0] OFS_BSTR  = 32'd16;
    localparam logic [31:0] OFS_CTRL  = 32'd20;
    localparam logic [31:0] OFS_DIM   = 32'd24;

    // Loop sums are one bit wider than a dimension so k+BLK_K cannot wrap.
    localparam int CW = DIM_W + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ZERO,
        S_WR_ASTR,
        S_WR_BSTR,
        S_WR_AADDR,
        S_WR_BADDR,
        S_WR_CADDR,
        S_WR_CTRL,
        S_WR_DIM,
        S_POLL_FULL,
        S_NEXT,
        S_POLL_DONE
    } state_t;

    state_t           r_state;
    logic [DIM_W-1:0] r_dim_m, r_dim_k, r_dim_n;
    logic [31:0]      r_a_base, r_b_base, r_c_base;
    logic [DIM_W-1:0] r_m, r_k, r_n;
    logic             r_poll_vld;
    logic             r_bus_en, r_bus_rdwr;
    logic [31:0]      r_bus_addr, r_bus_wr_data;
    logic             r_busy, r_done, r_err;
    logic [15:0]      r_tile_cnt;

    // Only bit 0 of the read data carries status.
    logic w_unused_rd;
    assign w_unused_rd = ^bus_rd_data[31:1];

    // A start is taken only from IDLE, and never in the cycle done is shown.
    logic w_start_acc;
    assign w_start_acc = (r_state == S_IDLE) && start && !r_done;

    logic w_dim_zero;
    assign w_dim_zero = (dim_m == '0) || (dim_k == '0) || (dim_n == '0);

    // Next loop positions and wrap detection.
    logic [CW-1:0] w_k_nxt, w_m_nxt, w_n_nxt;
    logic          w_k_wrap, w_m_wrap, w_n_wrap;
    assign w_k_nxt  = {1'b0, r_k} + CW'(BLK_K);
    assign w_m_nxt  = {1'b0, r_m} + CW'(BLK_M);
    assign w_n_nxt  = {1'b0, r_n} + CW'(BLK_N);
    assign w_k_wrap = w_k_nxt >= {1'b0, r_dim_k};
    assign w_m_wrap = w_m_nxt >= {1'b0, r_dim_m};
    assign w_n_wrap = w_n_nxt >= {1'b0, r_dim_n};

    // Remainders are never zero because each position stays below its dim.
    logic [DIM_W-1:0] w_m_rem, w_k_rem, w_n_rem;
    logic [4:0]       w_msize, w_ksize, w_nsize;
    assign w_m_rem = r_dim_m - r_m;
    assign w_k_rem = r_dim_k - r_k;
    assign w_n_rem = r_dim_n - r_n;
    assign w_msize = (w_m_rem >= DIM_W'(BLK_M)) ? 5'(BLK_M) : w_m_rem[4:0];
    assign w_ksize = (w_k_rem >= DIM_W'(BLK_K)) ? 5'(BLK_K) : w_k_rem[4:0];
    assign w_nsize = (w_n_rem >= DIM_W'(BLK_N)) ? 5'(BLK_N) : w_n_rem[4:0];

    // Tile register values; all address math is 32-bit with wrap.
    logic [31:0] w_a_addr, w_b_addr, w_c_addr, w_ctrl_word, w_dim_word;
    assign w_a_addr    = r_a_base + 32'(r_m) * 32'(r_dim_k) + 32'(r_k);
    assign w_b_addr    = r_b_base + 32'(r_n)
                       + (32'(r_k) + 32'(w_ksize) - 32'd1) * 32'(r_dim_n);
    assign w_c_addr    = r_c_base + 32'(r_m) * 32'(r_dim_n) + 32'(r_n);
    assign w_ctrl_word = {30'd0, (r_k == '0), w_k_wrap};
    assign w_dim_word  = {17'd0, w_nsize, w_ksize, w_msize};

    // Sequencer FSM; bus outputs are registered for the state being entered.
    // NOTE: every flop here uses <= so all branches see the same pre-edge
    // values; a blocking = would let later branches see half-updated state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_dim_m       <= '0;
            r_dim_k       <= '0;
            r_dim_n       <= '0;
            r_a_base      <= '0;
            r_b_base      <= '0;
            r_c_base      <= '0;
            r_m           <= '0;
            r_k           <= '0;
            r_n           <= '0;
            r_poll_vld    <= 1'b0;
            r_bus_en      <= 1'b0;
            r_bus_rdwr    <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_tile_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bus_en <= 1'b0;
                    if (w_start_acc) begin
                        r_dim_m    <= dim_m;
                        r_dim_k    <= dim_k;
                        r_dim_n    <= dim_n;
                        r_a_base   <= a_base;
                        r_b_base   <= b_base;
                        r_c_base   <= c_base;
                        r_m        <= '0;
                        r_k        <= '0;
                        r_n        <= '0;
                        r_tile_cnt <= '0;
                        r_busy     <= 1'b1;
                        if (w_dim_zero) begin
                            r_err   <= 1'b1;
                            r_state <= S_ZERO;
                        end else begin
                            r_err         <= 1'b0;
                            r_state       <= S_WR_ASTR;
                            r_bus_en      <= 1'b1;
                            r_bus_rdwr    <= 1'b1;
                            r_bus_addr    <= BASE_ADDR + OFS_ASTR;
                            r_bus_wr_data <= 32'(dim_k);
                        end
                    end
                end
                S_ZERO: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_WR_ASTR: begin
                    r_state       <= S_WR_BSTR;
                    r_bus_addr    <= BASE_ADDR + OFS_BSTR;
                    r_bus_wr_data <= 32'(r_dim_n);
                end
                S_WR_BSTR: begin
                    r_state       <= S_WR_AADDR;
                    r_bus_addr    <= BASE_ADDR + OFS_AADDR;
                    r_bus_wr_data <= w_a_addr;
                end
                S_WR_AADDR: begin
                    r_state       <= S_WR_BADDR;
                    r_bus_addr    <= BASE_ADDR + OFS_BADDR;
                    r_bus_wr_data <= w_b_addr;
                end
                S_WR_BADDR: begin
                    r_state       <= S_WR_CADDR;
                    r_bus_addr    <= BASE_ADDR + OFS_CADDR;
                    r_bus_wr_data <= w_c_addr;
                end
                S_WR_CADDR: begin
                    r_state       <= S_WR_CTRL;
                    r_bus_addr    <= BASE_ADDR + OFS_CTRL;
                    r_bus_wr_data <= w_ctrl_word;
                end
                S_WR_CTRL: begin
                    r_state       <= S_WR_DIM;
                    r_bus_addr    <= BASE_ADDR + OFS_DIM;
                    r_bus_wr_data <= w_dim_word;
                end
                S_WR_DIM: begin
                    r_state    <= S_POLL_FULL;
                    r_bus_rdwr <= 1'b0;
                    r_bus_addr <= BASE_ADDR;
                    r_poll_vld <= 1'b0;
                end
                S_POLL_FULL: begin
                    // First cycle only issues the read; data is valid after.
                    if (!r_poll_vld) begin
                        r_poll_vld <= 1'b1;
                    end else if (!bus_rd_data[0]) begin
                        r_state  <= S_NEXT;
                        r_bus_en <= 1'b0;
                    end
                end
                S_NEXT: begin
                    r_tile_cnt <= r_tile_cnt + 16'd1;
                    r_bus_en   <= 1'b1;
                    if (w_k_wrap) begin
                        r_k <= '0;
                        if (w_m_wrap) begin
                            r_m <= '0;
                            r_n <= w_n_nxt[DIM_W-1:0];
                        end else begin
                            r_m <= w_m_nxt[DIM_W-1:0];
                        end
                    end else begin
                        r_k <= w_k_nxt[DIM_W-1:0];
                    end
                    if (w_k_wrap && w_m_wrap && w_n_wrap) begin
                        r_state    <= S_POLL_DONE;
                        r_bus_rdwr <= 1'b0;
                        r_bus_addr <= BASE_ADDR + OFS_DIM;
                        r_poll_vld <= 1'b0;
                    end else begin
                        r_state       <= S_WR_ASTR;
                        r_bus_rdwr    <= 1'b1;
                        r_bus_addr    <= BASE_ADDR + OFS_ASTR;
                        r_bus_wr_data <= 32'(r_dim_k);
                    end
                end
                S_POLL_DONE: begin
                    if (!r_poll_vld) begin
                        r_poll_vld <= 1'b1;
                    end else if (bus_rd_data[0]) begin
                        r_state  <= S_IDLE;
                        r_bus_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_bus_en <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus_en      = r_bus_en;
    assign bus_rdwr    = r_bus_rdwr;
    assign bus_addr    = r_bus_addr;
    assign bus_wr_data = r_bus_wr_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign tile_cnt    = r_tile_cnt;

`ifdef GEMM_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_cycles, r_perf_stall;

    // Saturating busy-cycle and full-stall counters, cleared per job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else if (w_start_acc) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (r_busy && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if ((r_state == S_POLL_FULL) && bus_rd_data[0]
                && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stall  = r_perf_stall;
`else
    assign perf_cycles = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb_gemm_tile_sequencer
//   Directed bench for gemm_tile_sequencer with default 16x16x16 tiles.
//   A small bus responder answers the full poll (optionally reporting full
//   for a set number of cycles) and reports completion on the second done
//   poll cycle. Expected write streams come from a nested-loop tile model.
module tb_gemm_tile_sequencer;

    localparam logic [31:0] BASE = 32'h9000_0000;
    localparam int          TBLK = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dim_m = '0, dim_k = '0, dim_n = '0;
    logic [31:0] a_base = '0, b_base = '0, c_base = '0;
    logic        bus_en, bus_rdwr;
    logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
    logic        busy, done, err;
    logic [15:0] tile_cnt;
    logic [31:0] perf_cycles, perf_stall;

    gemm_tile_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dim_m      (dim_m),
        .dim_k      (dim_k),
        .dim_n      (dim_n),
        .a_base     (a_base),
        .b_base     (b_base),
        .c_base     (c_base),
        .bus_en     (bus_en),
        .bus_rdwr   (bus_rdwr),
        .bus_addr   (bus_addr),
        .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .tile_cnt   (tile_cnt),
        .perf_cycles(perf_cycles),
        .perf_stall (perf_stall)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus responder and write/poll monitor.
    int          full_cfg = 0;
    int          poll_seen = 0;
    int          done_seen = 0;
    logic [63:0] wr_q[$];
    int          runs_q[$];
    logic        w_poll_full, w_poll_done, w_rd_bit;

    assign w_poll_full = bus_en && !bus_rdwr && (bus_addr == BASE);
    assign w_poll_done = bus_en && !bus_rdwr && (bus_addr == BASE + 32'd24);
    assign w_rd_bit    = w_poll_full ? (poll_seen < full_cfg) : (done_seen >= 1);
    assign bus_rd_data = {31'd0, w_rd_bit};

    always @(posedge clk) begin
        if (bus_en && bus_rdwr) wr_q.push_back({bus_addr, bus_wr_data});
        if (w_poll_full) begin
            poll_seen <= poll_seen + 1;
        end else begin
            if (poll_seen != 0) runs_q.push_back(poll_seen);
            poll_seen <= 0;
        end
        if (w_poll_done) done_seen <= done_seen + 1;
        else             done_seen <= 0;
    end

    // Expected write stream for one job.
    logic [63:0] exp_q[$];

    function automatic void build_exp(input int mm, input int kk, input int nn,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
        exp_q.delete();
        for (int n = 0; n < nn; n += TBLK) begin
            for (int m = 0; m < mm; m += TBLK) begin
                for (int k = 0; k < kk; k += TBLK) begin
                    int ks, ms, ns;
                    logic [31:0] aa, bb, cc, dw, cw;
                    ks = (kk - k < TBLK) ? kk - k : TBLK;
                    ms = (mm - m < TBLK) ? mm - m : TBLK;
                    ns = (nn - n < TBLK) ? nn - n : TBLK;
                    aa = a + 32'(m * kk + k);
                    bb = b + 32'(n) + 32'((k + ks - 1) * nn);
                    cc = c + 32'(m * nn + n);
                    dw = 32'(ms + ks * 32 + ns * 1024);
                    cw = {30'd0, (k == 0), (k + TBLK >= kk)};
                    exp_q.push_back({BASE + 32'd12, 32'(kk)});
                    exp_q.push_back({BASE + 32'd16, 32'(nn)});
                    exp_q.push_back({BASE,          aa});
                    exp_q.push_back({BASE + 32'd4,  bb});
                    exp_q.push_back({BASE + 32'd8,  cc});
                    exp_q.push_back({BASE + 32'd20, cw});
                    exp_q.push_back({BASE + 32'd24, dw});
                end
            end
        end
    endfunction

    task automatic compare_writes(input string tag, input int mark);
        int n;
        check({tag, "_wr_count"}, 32'(wr_q.size() - mark), 32'(exp_q.size()));
        n = wr_q.size() - mark;
        if (n > exp_q.size()) n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_q[mark+i][63:32], exp_q[i][63:32]);
            check($sformatf("%s_data%0d", tag, i), wr_q[mark+i][31:0],  exp_q[i][31:0]);
        end
    endtask

    // Pulses start, optionally re-pulses it mid-job and on done, waits for done.
    task automatic run_job(input string tag, input int mm, input int kk, input int nn,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input int extra_at, input bit start_on_done);
        bit got_done;
        @(negedge clk);
        dim_m = 16'(mm); dim_k = 16'(kk); dim_n = 16'(nn);
        a_base = a; b_base = b; c_base = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_on_start"}, 32'(busy), 32'd1);
        got_done = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done) begin
                got_done = 1'b1;
                if (start_on_done) begin
                    start = 1'b1;
                    dim_m = 16'd5; dim_k = 16'd5; dim_n = 16'd5;
                end
                break;
            end
            if (cyc == extra_at) begin
                start = 1'b1;
                dim_m = 16'd3; dim_k = 16'd3; dim_n = 16'd3;
                a_base = 32'h1234; b_base = 32'h5678; c_base = 32'h9abc;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        int  mark, rmark, en_cnt;
        bit  found;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_bus_en",   32'(bus_en),   32'd0);
        check("rst_bus_rdwr", 32'(bus_rdwr), 32'd0);
        check("rst_bus_addr", bus_addr,      32'd0);
        check("rst_wr_data",  bus_wr_data,   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_tile_cnt", 32'(tile_cnt), 32'd0);
        check("rst_perf_cyc", perf_cycles,   32'd0);
        check("rst_perf_stl", perf_stall,    32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single tile.
        mark  = wr_q.size();
        rmark = runs_q.size();
        run_job("single", 16, 16, 16, 32'd0, 32'd256, 32'd512, -1, 1'b0);
        build_exp(16, 16, 16, 32'd0, 32'd256, 32'd512);
        compare_writes("single", mark);
        check("single_A",    wr_q[mark+2][31:0], 32'd0);
        check("single_B",    wr_q[mark+3][31:0], 32'd496);
        check("single_C",    wr_q[mark+4][31:0], 32'd512);
        check("single_CTRL", wr_q[mark+5][31:0], 32'd3);
        check("single_DIM",  wr_q[mark+6][31:0], 32'd16912);
        check("single_tiles", 32'(tile_cnt), 32'd1);
        check("single_poll_len", 32'(runs_q[rmark]), 32'd2);
        check("idle_bus_en",   32'(bus_en), 32'd0);
        check("idle_addr_hold", bus_addr, BASE + 32'd24);
        check("idle_data_hold", bus_wr_data, 32'd16912);

        // Ragged 20x20x20.
        mark = wr_q.size();
        run_job("ragged", 20, 20, 20, 32'd0, 32'd400, 32'd800, -1, 1'b0);
        build_exp(20, 20, 20, 32'd0, 32'd400, 32'd800);
        compare_writes("ragged", mark);
        check("ragged_tiles",   32'(tile_cnt), 32'd8);
        check("ragged_t0_CTRL", wr_q[mark+5][31:0],  32'd2);
        check("ragged_t1_A",    wr_q[mark+9][31:0],  32'd16);
        check("ragged_t1_CTRL", wr_q[mark+12][31:0], 32'd1);
        check("ragged_t1_DIM",  wr_q[mark+13][31:0], 32'd16528);
        check("ragged_last_A",    wr_q[mark+51][31:0], 32'd336);
        check("ragged_last_B",    wr_q[mark+52][31:0], 32'd796);
        check("ragged_last_C",    wr_q[mark+53][31:0], 32'd1136);
        check("ragged_last_CTRL", wr_q[mark+54][31:0], 32'd1);
        check("ragged_last_DIM",  wr_q[mark+55][31:0], 32'd4228);

        // Backpressure: engine reports full for 5 poll cycles.
        full_cfg = 5;
        mark  = wr_q.size();
        rmark = runs_q.size();
        run_job("bp", 16, 16, 16, 32'd0, 32'd256, 32'd512, -1, 1'b0);
        full_cfg = 0;
        check("bp_wr_count", 32'(wr_q.size() - mark), 32'd7);
        check("bp_poll_len", 32'(runs_q[rmark]), 32'd6);
`ifdef GEMM_SEQ_PERF_CNT_EN
        check("bp_perf_stall",  perf_stall,  32'd5);
        check("bp_perf_cycles", perf_cycles, 32'd16);
`else
        check("bp_perf_stall",  perf_stall,  32'd0);
        check("bp_perf_cycles", perf_cycles, 32'd0);
`endif

        // Zero dimension.
        mark = wr_q.size();
        @(negedge clk);
        dim_m = 16'd16; dim_k = 16'd0; dim_n = 16'd16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_err",    32'(err),    32'd1);
        check("zero_done0",  32'(done),   32'd0);
        check("zero_bus_en", 32'(bus_en), 32'd0);
        @(negedge clk);
        check("zero_done1",  32'(done),   32'd1);
        check("zero_bus_en2", 32'(bus_en), 32'd0);
        @(negedge clk);
        check("zero_done_off", 32'(done), 32'd0);
        check("zero_no_writes", 32'(wr_q.size() - mark), 32'd0);
        run_job("after_zero", 16, 16, 16, 32'd0, 32'd256, 32'd512, -1, 1'b0);
        check("err_cleared", 32'(err), 32'd0);

        // Reset during WR_BADDR of the third tile.
        @(negedge clk);
        dim_m = 16'd20; dim_k = 16'd20; dim_n = 16'd20;
        a_base = 32'd0; b_base = 32'd400; c_base = 32'd800;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (tile_cnt == 16'd2 && bus_en && bus_rdwr && bus_addr == BASE + 32'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstjob_reached_t3_baddr", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstjob_bus_en",   32'(bus_en),   32'd0);
        check("rstjob_bus_rdwr", 32'(bus_rdwr), 32'd0);
        check("rstjob_addr",     bus_addr,      32'd0);
        check("rstjob_data",     bus_wr_data,   32'd0);
        check("rstjob_busy",     32'(busy),     32'd0);
        check("rstjob_tiles",    32'(tile_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_en) en_cnt++;
        end
        check("rstjob_no_traffic", 32'(en_cnt), 32'd0);
        mark = wr_q.size();
        run_job("rerun", 16, 16, 16, 32'd0, 32'd256, 32'd512, -1, 1'b0);
        build_exp(16, 16, 16, 32'd0, 32'd256, 32'd512);
        compare_writes("rerun", mark);
        check("rerun_tiles", 32'(tile_cnt), 32'd1);

        // Extra starts mid-job and on done are ignored.
        mark = wr_q.size();
        run_job("ignore", 20, 20, 20, 32'd0, 32'd400, 32'd800, 20, 1'b1);
        build_exp(20, 20, 20, 32'd0, 32'd400, 32'd800);
        compare_writes("ignore", mark);
        check("ignore_tiles", 32'(tile_cnt), 32'd8);
        @(negedge clk);
        check("ignore_still_idle", 32'(busy),   32'd0);
        check("ignore_no_bus",     32'(bus_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
